smul_accumulator: RTL and testbench

Accumulation stage that sits directly downstream of the signed multiplier in each DTPU MAC cell. It consumes the multiplier's 64-bit product stream, adds it to the partial sum arriving from the row above, and accumulates `acc_len` products per output. It emits a saturated, sign-extended 64-bit result with a one-cycle valid pulse. The precision encoding matches the multiplier: one-hot `select_precision`, with bits [0..3] selecting INT8, INT16, INT32 and INT64.

---
 rtl/smul_accumulator.sv | 136 +++++++++++++
 tb/tb_smul_accumulator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/smul_accumulator.sv
// Accumulation stage behind the signed multiplier of a DTPU MAC cell.
// Two register stages: sign-extend/qualify, then add-saturate-count.
module smul_accumulator #(
   parameter int unsigned ACC_LEN_W = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ce,
   input  logic                 sclr,
   input  logic [3:0]           select_precision,
   input  logic [63:0]          product_in,
   input  logic                 product_valid,
   input  logic [63:0]          psum_in,
   input  logic [ACC_LEN_W-1:0] acc_len,
   output logic [63:0]          result,
   output logic                 result_valid,
   output logic                 sat_flag,
   output logic                 busy
);

   logic [63:0]          r_p1, r_s1, r_acc, r_result;
   logic                 r_v1, r_sticky, r_rv, r_sat_flag;
   logic [1:0]           r_w1, r_wg;
   logic [ACC_LEN_W-1:0] r_cnt;

   logic                 w_prec_ok, w_first, w_final, w_clamp, w_sticky_nxt;
   logic [1:0]           w_prec, w_wg;
   logic [ACC_LEN_W-1:0] w_len_m1;
   logic [63:0]          w_base, w_sat_val;
   logic signed [65:0]   w_sum, w_max, w_min;

   function automatic logic [63:0] f_sext(input logic [63:0] x, input logic [1:0] p);
      case (p)
         2'd0:    return {{56{x[7]}},  x[7:0]};
         2'd1:    return {{48{x[15]}}, x[15:0]};
         2'd2:    return {{32{x[31]}}, x[31:0]};
         default: return x;
      endcase
   endfunction

   // Lowest set bit of the one-hot select wins.
   always_comb begin
      w_prec_ok = |select_precision;
      w_prec    = 2'd0;
      if (select_precision[0])      w_prec = 2'd0;
      else if (select_precision[1]) w_prec = 2'd1;
      else if (select_precision[2]) w_prec = 2'd2;
      else if (select_precision[3]) w_prec = 2'd3;
   end

   always_comb begin
      w_first  = (r_cnt == '0);
      w_wg     = w_first ? r_w1 : r_wg;
      w_base   = w_first ? r_s1 : r_acc;
      w_len_m1 = (acc_len == '0) ? '0 : acc_len - ACC_LEN_W'(1);
      w_final  = (r_cnt >= w_len_m1);
      w_sum    = $signed({{2{w_base[63]}}, w_base}) + $signed({{2{r_p1[63]}}, r_p1});
      case (w_wg)
         2'd0: begin w_max = 66'sd127;        w_min = -66'sd128;        end
         2'd1: begin w_max = 66'sd32767;      w_min = -66'sd32768;      end
         2'd2: begin w_max = 66'sd2147483647; w_min = -66'sd2147483648; end
         default: begin
            w_max = $signed({3'b000, {63{1'b1}}});
            w_min = $signed({3'b111, {63{1'b0}}});
         end
      endcase
      w_clamp   = 1'b0;
      w_sat_val = w_sum[63:0];
      if (w_sum > w_max) begin
         w_clamp   = 1'b1;
         w_sat_val = w_max[63:0];
      end else if (w_sum < w_min) begin
         w_clamp   = 1'b1;
         w_sat_val = w_min[63:0];
      end
      w_sticky_nxt = (w_first ? 1'b0 : r_sticky) | w_clamp;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_p1 <= '0;
         r_s1 <= '0;
         r_v1 <= 1'b0;
         r_w1 <= '0;
      end else if (sclr) begin
         r_v1 <= 1'b0;
      end else if (ce) begin
         r_p1 <= f_sext(product_in, w_prec);
         r_s1 <= f_sext(psum_in, w_prec);
         r_v1 <= product_valid & w_prec_ok;
         r_w1 <= w_prec;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc      <= '0;
         r_cnt      <= '0;
         r_wg       <= '0;
         r_sticky   <= 1'b0;
         r_result   <= '0;
         r_rv       <= 1'b0;
         r_sat_flag <= 1'b0;
      end else if (sclr) begin
         r_acc      <= '0;
         r_cnt      <= '0;
         r_sticky   <= 1'b0;
         r_result   <= '0;
         r_rv       <= 1'b0;
         r_sat_flag <= 1'b0;
      end else if (ce) begin
         r_rv <= 1'b0;
         if (r_v1) begin
            if (w_first) r_wg <= r_w1;
            if (w_final) begin
               r_result   <= w_sat_val;
               r_rv       <= 1'b1;
               r_sat_flag <= w_sticky_nxt;
               r_cnt      <= '0;
               r_acc      <= '0;
               r_sticky   <= 1'b0;
            end else begin
               r_cnt    <= r_cnt + ACC_LEN_W'(1);
               r_acc    <= w_sat_val;
               r_sticky <= w_sticky_nxt;
            end
         end
      end
   end

   assign result       = r_result;
   assign result_valid = r_rv;
   assign sat_flag     = r_sat_flag;
   assign busy         = (r_cnt != '0) | r_v1;

endmodule

// File: tb/tb_smul_accumulator.sv
// Directed bench for smul_accumulator with hand-computed expectations.
module tb_smul_accumulator;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce = 1'b1;
   logic        sclr = 1'b0;
   logic [3:0]  select_precision = 4'b0001;
   logic [63:0] product_in = '0;
   logic        product_valid = 1'b0;
   logic [63:0] psum_in = '0;
   logic [7:0]  acc_len = 8'd1;
   logic [63:0] result;
   logic        result_valid, sat_flag, busy;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   smul_accumulator #(.ACC_LEN_W(8)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .ce               (ce),
      .sclr             (sclr),
      .select_precision (select_precision),
      .product_in       (product_in),
      .product_valid    (product_valid),
      .psum_in          (psum_in),
      .acc_len          (acc_len),
      .result           (result),
      .result_valid     (result_valid),
      .sat_flag         (sat_flag),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic pv, input logic [63:0] prod, input logic [63:0] ps);
      product_valid = pv;
      product_in    = prod;
      psum_in       = ps;
   endtask

   task automatic chk_out(input string tag, input logic rv, input logic [63:0] res, input logic sf);
      chk({tag, ".rv"},  {63'd0, result_valid}, {63'd0, rv});
      chk({tag, ".res"}, result, res);
      chk({tag, ".sat"}, {63'd0, sat_flag}, {63'd0, sf});
   endtask

   initial begin
      #12;
      chk_out("rst", 1'b0, 64'd0, 1'b0);
      chk("rst.busy", {63'd0, busy}, 64'd0);
      reset_n = 1'b1;
      tick;

      // INT8 accumulate: 10+1+2+3+4 = 20
      select_precision = 4'b0001; acc_len = 8'd4;
      drive(1'b1, 64'd1, 64'd10); tick;
      chk("acc.busy", {63'd0, busy}, 64'd1);
      drive(1'b1, 64'd2, 64'd10); tick;
      drive(1'b1, 64'd3, 64'd10); tick;
      drive(1'b1, 64'd4, 64'd10); tick;
      chk("acc.early", {63'd0, result_valid}, 64'd0);
      drive(1'b0, 64'd0, 64'd10); tick;
      chk_out("acc", 1'b1, 64'd20, 1'b0);
      tick;
      chk("acc.drop", {63'd0, result_valid}, 64'd0);
      chk("acc.idle", {63'd0, busy}, 64'd0);

      // INT8 positive saturation: 100+20+30 -> 127
      acc_len = 8'd2;
      drive(1'b1, 64'd20, 64'd100); tick;
      drive(1'b1, 64'd30, 64'd100); tick;
      drive(1'b0, 64'd0, 64'd100); tick;
      chk_out("satp", 1'b1, 64'h7F, 1'b1);

      // INT8 negative saturation: -100-20-30 -> -128
      drive(1'b1, -64'sd20, -64'sd100); tick;
      drive(1'b1, -64'sd30, -64'sd100); tick;
      drive(1'b0, 64'd0, -64'sd100); tick;
      chk_out("satn", 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);

      // INT64 overflow
      select_precision = 4'b1000; acc_len = 8'd1;
      drive(1'b1, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF); tick;
      drive(1'b0, 64'd0, 64'd0); tick;
      chk_out("i64", 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
      tick;

      // INT16 gapped stream with ce stall: 5+6+7 = 18
      select_precision = 4'b0010; acc_len = 8'd3;
      drive(1'b1, 64'd5, 64'd0); tick;
      drive(1'b0, 64'd0, 64'd0); tick;
      drive(1'b1, 64'd6, 64'd0); tick;
      ce = 1'b0;
      drive(1'b0, 64'd0, 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("gap.stall_rv", {63'd0, result_valid}, 64'd0);
         chk("gap.stall_busy", {63'd0, busy}, 64'd1);
      end
      ce = 1'b1;
      drive(1'b1, 64'd7, 64'd0); tick;
      chk("gap.early", {63'd0, result_valid}, 64'd0);
      drive(1'b0, 64'd0, 64'd0); tick;
      chk_out("gap", 1'b1, 64'd18, 1'b0);
      ce = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("gap.hold_rv", {63'd0, result_valid}, 64'd1);
      end
      ce = 1'b1; tick;
      chk("gap.drop", {63'd0, result_valid}, 64'd0);

      // Precision change mid-group: group stays INT8, 100+20+30 -> 127
      select_precision = 4'b0001; acc_len = 8'd2;
      drive(1'b1, 64'd20, 64'd100); tick;
      select_precision = 4'b0100;
      drive(1'b1, 64'd30, 64'd100); tick;
      drive(1'b0, 64'd0, 64'd0); tick;
      chk_out("prec", 1'b1, 64'h7F, 1'b1);
      tick;

      // sclr after 2nd term
      select_precision = 4'b0001; acc_len = 8'd4;
      drive(1'b1, 64'd1, 64'd50); tick;
      drive(1'b1, 64'd2, 64'd50); tick;
      drive(1'b0, 64'd0, 64'd50); sclr = 1'b1; tick;
      sclr = 1'b0;
      chk_out("sclr", 1'b0, 64'd0, 1'b0);
      chk("sclr.busy", {63'd0, busy}, 64'd0);
      tick;
      chk("sclr.nopulse", {63'd0, result_valid}, 64'd0);
      acc_len = 8'd1;
      drive(1'b1, 64'd3, 64'd7); tick;
      drive(1'b0, 64'd0, 64'd0); tick;
      chk_out("sclr.fresh", 1'b1, 64'd10, 1'b0);

      // sclr with a valid product: term discarded
      sclr = 1'b1; drive(1'b1, 64'd99, 64'd0); tick;
      sclr = 1'b0; drive(1'b0, 64'd0, 64'd0); tick;
      chk("sclrpv.busy", {63'd0, busy}, 64'd0);
      chk("sclrpv.rv", {63'd0, result_valid}, 64'd0);

      // acc_len = 0 behaves as 1: 2+5 = 7
      acc_len = 8'd0;
      drive(1'b1, 64'd5, 64'd2); tick;
      drive(1'b0, 64'd0, 64'd0); tick;
      chk_out("len0", 1'b1, 64'd7, 1'b0);
      tick;

      // Back-to-back single-term groups
      select_precision = 4'b0010; acc_len = 8'd1;
      drive(1'b1, 64'd3, 64'd100); tick;
      drive(1'b1, 64'd4, 64'd100); tick;
      chk_out("b2b.0", 1'b1, 64'd103, 1'b0);
      drive(1'b0, 64'd0, 64'd0); tick;
      chk_out("b2b.1", 1'b1, 64'd104, 1'b0);

      // Async reset mid-group
      acc_len = 8'd3;
      drive(1'b1, 64'd1, 64'd1); tick;
      drive(1'b1, 64'd2, 64'd1); tick;
      drive(1'b0, 64'd0, 64'd0);
      #2 reset_n = 1'b0;
      #1;
      chk_out("arst", 1'b0, 64'd0, 1'b0);
      chk("arst.busy", {63'd0, busy}, 64'd0);
      #2 reset_n = 1'b1;
      tick;
      acc_len = 8'd1;
      drive(1'b1, 64'd6, 64'd5); tick;
      chk("post.early", {63'd0, result_valid}, 64'd0);
      drive(1'b0, 64'd0, 64'd0); tick;
      chk_out("post", 1'b1, 64'd11, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
